// File: rtl/n25q_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n25q_pkg
// Description : Shared opcodes, default terminal addresses and FSM state
//               encodings for the N25Q page-program sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package n25q_pkg;

    // N25Q command opcodes
    localparam logic [7:0]  OP_WREN = 8'h06;
    localparam logic [7:0]  OP_PP   = 8'h02;
    localparam logic [7:0]  OP_RDSR = 8'h05;

    // Default terminal addresses of the N25Q controller
    localparam logic [15:0] C_DEF_TERM_CTRL = 16'h0010;
    localparam logic [15:0] C_DEF_TERM_DATA = 16'h0011;

    // Page-program sequencer states
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHK_LEN   = 4'd1,
        S_WREN_CSLO = 4'd2,
        S_WREN      = 4'd3,
        S_WREN_CSHI = 4'd4,
        S_PP_CSLO   = 4'd5,
        S_PP_HDR    = 4'd6,
        S_PP_DATA   = 4'd7,
        S_PP_CSHI   = 4'd8,
        S_POLL_CSLO = 4'd9,
        S_RDSR      = 4'd10,
        S_POLL_CSHI = 4'd11,
        S_CHECK     = 4'd12,
        S_DONE      = 4'd13,
        S_ERR       = 4'd14
    } pp_state_t;

    // Single-transfer engine states
    typedef enum logic [2:0] {
        X_IDLE   = 3'd0,
        X_SETUP  = 3'd1,
        X_STROBE = 3'd2,
        X_WAIT   = 3'd3,
        X_RDY    = 3'd4,
        X_READ   = 3'd5
    } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/n25q_di_xfer.sv
`default_nettype none
// ============================================================================
// Module      : n25q_di_xfer
// Description : Issues one register-style transfer on the N25Q di_* bus and
//               waits for the slave to report ready. Address, mode, length
//               and data stay on the bus until the next request.
// Revision    : 1.0 - initial release
// ============================================================================
module n25q_di_xfer
    import n25q_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_read,
    input  logic        i_ctrl,
    input  logic [15:0] i_term,
    input  logic [31:0] i_reg,
    input  logic [31:0] i_len,
    input  logic [31:0] i_data,
    output logic        o_idle,
    output logic        o_ack,
    output logic [7:0]  o_rdata,
    output logic [15:0] o_di_term_addr,
    output logic [31:0] o_di_reg_addr,
    output logic        o_di_read_mode,
    output logic        o_di_read_req,
    output logic        o_di_read,
    output logic        o_di_write_mode,
    output logic        o_di_write,
    output logic [31:0] o_di_len,
    output logic [31:0] o_di_reg_datai,
    input  logic        i_di_read_rdy,
    input  logic        i_di_write_rdy,
    input  logic [31:0] i_di_reg_datao
);

    xfer_state_t r_state;
    xfer_state_t w_state_nxt;
    logic        r_read;
    logic        r_ctrl;
    logic [7:0]  w_last_byte;

    // The response byte is the last byte of the frame, so its lane follows the length
    always_comb begin
        w_last_byte = i_di_reg_datao[31:24];
        case (o_di_len[1:0])
            2'd1:    w_last_byte = i_di_reg_datao[7:0];
            2'd2:    w_last_byte = i_di_reg_datao[15:8];
            2'd3:    w_last_byte = i_di_reg_datao[23:16];
            default: w_last_byte = i_di_reg_datao[31:24];
        endcase
    end

    // State register, held bus fields and captured read byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= X_IDLE;
            r_read          <= 1'b0;
            r_ctrl          <= 1'b0;
            o_rdata         <= 8'd0;
            o_di_term_addr  <= 16'd0;
            o_di_reg_addr   <= 32'd0;
            o_di_read_mode  <= 1'b0;
            o_di_write_mode <= 1'b0;
            o_di_len        <= 32'd0;
            o_di_reg_datai  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == X_IDLE && i_req) begin
                r_read          <= i_read;
                r_ctrl          <= i_ctrl;
                o_di_term_addr  <= i_term;
                o_di_reg_addr   <= i_reg;
                o_di_read_mode  <= i_read;
                o_di_write_mode <= ~i_read;
                o_di_len        <= i_len;
                o_di_reg_datai  <= i_data;
            end
            if (r_state == X_RDY && r_read && i_di_read_rdy) begin
                o_rdata <= w_last_byte;
            end
        end
    end

    // Next state and strobes; the slave drops ready one cycle after a strobe,
    // so the cycle after the strobe never trusts ready except for control writes
    always_comb begin
        w_state_nxt   = r_state;
        o_idle        = 1'b0;
        o_ack         = 1'b0;
        o_di_write    = 1'b0;
        o_di_read_req = 1'b0;
        o_di_read     = 1'b0;
        case (r_state)
            X_IDLE: begin
                o_idle = 1'b1;
                if (i_req) w_state_nxt = X_SETUP;
            end
            X_SETUP:  w_state_nxt = X_STROBE;
            X_STROBE: begin
                if (r_read) o_di_read_req = 1'b1;
                else        o_di_write    = 1'b1;
                w_state_nxt = X_WAIT;
            end
            X_WAIT: begin
                if (r_ctrl && i_di_write_rdy) begin
                    o_ack       = 1'b1;
                    w_state_nxt = X_IDLE;
                end else begin
                    w_state_nxt = X_RDY;
                end
            end
            X_RDY: begin
                if (r_read) begin
                    if (i_di_read_rdy) w_state_nxt = X_READ;
                end else if (i_di_write_rdy) begin
                    o_ack       = 1'b1;
                    w_state_nxt = X_IDLE;
                end
            end
            X_READ: begin
                o_di_read   = 1'b1;
                o_ack       = 1'b1;
                w_state_nxt = X_IDLE;
            end
            default: w_state_nxt = X_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/n25q_page_prog_seq.sv
`default_nettype none
// ============================================================================
// Module      : n25q_page_prog_seq
// Description : Page-program sequencer for the N25Q controller: WREN frame,
//               PAGE PROGRAM frame with streamed payload, then RDSR polling
//               until the write-in-progress bit clears.
// Revision    : 1.0 - initial release
// ============================================================================
module n25q_page_prog_seq
    import n25q_pkg::*;
#(
    parameter logic [15:0] TERM_CTRL = C_DEF_TERM_CTRL,
    parameter logic [15:0] TERM_DATA = C_DEF_TERM_DATA,
    parameter logic [31:0] REG_CSB   = 32'd0,
    parameter logic [19:0] POLL_MAX  = 20'd1000000
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] page_addr,
    input  logic [8:0]  nbytes,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic        di_read_mode,
    output logic        di_read_req,
    output logic        di_read,
    output logic        di_write_mode,
    output logic        di_write,
    output logic [31:0] di_len,
    output logic [31:0] di_reg_datai,
    input  logic        di_read_rdy,
    input  logic        di_write_rdy,
    input  logic [31:0] di_reg_datao
);

    pp_state_t   r_state;
    pp_state_t   w_state_nxt;
    logic [23:0] r_addr;
    logic [8:0]  r_nbytes;
    logic [6:0]  r_words_left;
    logic [19:0] r_poll_cnt;
    logic [7:0]  r_status;
    logic        r_issued;

    logic        w_x_req;
    logic        w_x_read;
    logic        w_x_ctrl;
    logic [15:0] w_x_term;
    logic [31:0] w_x_reg;
    logic [31:0] w_x_len;
    logic [31:0] w_x_data;
    logic        w_x_idle;
    logic        w_x_ack;
    logic [7:0]  w_x_rdata;
    logic        w_can_issue;
    logic        w_bad_len;
    logic [31:0] w_pp_len;

    assign w_can_issue = ~r_issued & w_x_idle;
    assign w_bad_len   = (r_nbytes == 9'd0) || (r_nbytes > 9'd256);
    assign w_pp_len    = 32'd4 + 32'(r_nbytes);
    assign status      = r_status;
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign done        = (r_state == S_DONE);
    assign error       = (r_state == S_ERR);

    // State register
    always_ff @(posedge ifclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Request latch, word/poll counters, issue flag and status capture
    always_ff @(posedge ifclk) begin
        if (reset) begin
            r_addr       <= 24'd0;
            r_nbytes     <= 9'd0;
            r_words_left <= 7'd0;
            r_poll_cnt   <= 20'd0;
            r_status     <= 8'd0;
            r_issued     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_addr       <= page_addr;
                r_nbytes     <= nbytes;
                r_words_left <= 7'((10'(nbytes) + 10'd3) >> 2);
                r_poll_cnt   <= 20'd0;
            end
            if (w_x_ack)      r_issued <= 1'b0;
            else if (w_x_req) r_issued <= 1'b1;
            if (r_state == S_PP_DATA && w_x_ack) r_words_left <= r_words_left - 7'd1;
            if (r_state == S_RDSR && w_x_ack)    r_status     <= w_x_rdata;
            if (r_state == S_CHECK && r_status[0] && r_poll_cnt < POLL_MAX)
                r_poll_cnt <= r_poll_cnt + 20'd1;
        end
    end

    // Transfer selection per state and sequencing on transfer completion
    always_comb begin
        w_state_nxt = r_state;
        w_x_req     = 1'b0;
        w_x_read    = 1'b0;
        w_x_ctrl    = 1'b0;
        w_x_term    = TERM_DATA;
        w_x_reg     = 32'd0;
        w_x_len     = 32'd0;
        w_x_data    = 32'd0;
        wr_ready    = 1'b0;

        case (r_state)
            S_WREN_CSLO, S_PP_CSLO, S_POLL_CSLO,
            S_WREN_CSHI, S_PP_CSHI, S_POLL_CSHI: begin
                w_x_req  = w_can_issue;
                w_x_ctrl = 1'b1;
                w_x_term = TERM_CTRL;
                w_x_reg  = REG_CSB;
                w_x_len  = 32'd4;
                w_x_data = ((r_state == S_WREN_CSHI) || (r_state == S_PP_CSHI) ||
                            (r_state == S_POLL_CSHI)) ? 32'd1 : 32'd0;
            end
            S_WREN: begin
                w_x_req  = w_can_issue;
                w_x_len  = 32'd1;
                w_x_data = {24'd0, OP_WREN};
            end
            S_PP_HDR: begin
                w_x_req  = w_can_issue;
                w_x_len  = w_pp_len;
                w_x_data = {r_addr[7:0], r_addr[15:8], r_addr[23:16], OP_PP};
            end
            S_PP_DATA: begin
                wr_ready = w_can_issue && (r_words_left != 7'd0);
                w_x_req  = wr_ready && wr_valid;
                w_x_len  = w_pp_len;
                w_x_data = wr_data;
            end
            S_RDSR: begin
                w_x_req  = w_can_issue;
                w_x_read = 1'b1;
                w_x_len  = 32'd2;
                w_x_data = {24'd0, OP_RDSR};
            end
            default: ;
        endcase

        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_CHK_LEN;
            S_CHK_LEN:   w_state_nxt = w_bad_len ? S_ERR : S_WREN_CSLO;
            S_WREN_CSLO: if (w_x_ack) w_state_nxt = S_WREN;
            S_WREN:      if (w_x_ack) w_state_nxt = S_WREN_CSHI;
            S_WREN_CSHI: if (w_x_ack) w_state_nxt = S_PP_CSLO;
            S_PP_CSLO:   if (w_x_ack) w_state_nxt = S_PP_HDR;
            S_PP_HDR:    if (w_x_ack) w_state_nxt = S_PP_DATA;
            S_PP_DATA:   if (w_x_ack && r_words_left == 7'd1) w_state_nxt = S_PP_CSHI;
            S_PP_CSHI:   if (w_x_ack) w_state_nxt = S_POLL_CSLO;
            S_POLL_CSLO: if (w_x_ack) w_state_nxt = S_RDSR;
            S_RDSR:      if (w_x_ack) w_state_nxt = S_POLL_CSHI;
            S_POLL_CSHI: if (w_x_ack) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (r_status[0] && r_poll_cnt < POLL_MAX) w_state_nxt = S_POLL_CSLO;
                else if (r_status[0])                     w_state_nxt = S_ERR;
                else                                      w_state_nxt = S_DONE;
            end
            S_DONE, S_ERR: w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    n25q_di_xfer u_xfer (
        .clk             (ifclk),
        .rst             (reset),
        .i_req           (w_x_req),
        .i_read          (w_x_read),
        .i_ctrl          (w_x_ctrl),
        .i_term          (w_x_term),
        .i_reg           (w_x_reg),
        .i_len           (w_x_len),
        .i_data          (w_x_data),
        .o_idle          (w_x_idle),
        .o_ack           (w_x_ack),
        .o_rdata         (w_x_rdata),
        .o_di_term_addr  (di_term_addr),
        .o_di_reg_addr   (di_reg_addr),
        .o_di_read_mode  (di_read_mode),
        .o_di_read_req   (di_read_req),
        .o_di_read       (di_read),
        .o_di_write_mode (di_write_mode),
        .o_di_write      (di_write),
        .o_di_len        (di_len),
        .o_di_reg_datai  (di_reg_datai),
        .i_di_read_rdy   (di_read_rdy),
        .i_di_write_rdy  (di_write_rdy),
        .i_di_reg_datao  (di_reg_datao)
    );

endmodule
`default_nettype wire

// File: tb/tb_n25q_page_prog_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_n25q_page_prog_seq
// Description : Directed self-checking bench for n25q_page_prog_seq with a
//               small N25Q terminal model that logs every di transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n25q_page_prog_seq;

    localparam logic [15:0] C_CTRL = 16'h0010;
    localparam logic [15:0] C_DATA = 16'h0011;

    logic        ifclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] page_addr = 24'd0;
    logic [8:0]  nbytes = 9'd0;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready, busy, done, error;
    logic [7:0]  status;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr, di_len, di_reg_datai, di_reg_datao;
    logic        di_read_mode, di_read_req, di_read, di_write_mode, di_write;
    logic        di_read_rdy, di_write_rdy;

    // terminal model state
    logic        csb;
    logic [2:0]  dly;
    int          log_n = 0, rd_cnt = 0, acc_cnt = 0, done_cnt = 0;
    logic [15:0] lg_term [0:127];
    logic [31:0] lg_data [0:127];
    logic [31:0] lg_len  [0:127];
    logic        lg_rd   [0:127];

    // stimulus controls (written by the initial block only)
    int          rd_base = 0, acc_base = 0, wip_polls = 0, feed_n = 0;
    logic        wip_stuck = 1'b0;
    logic [31:0] feed [0:3];
    int          acc_rel;
    logic [7:0]  sts_byte;

    int n_cmp = 0, n_fail = 0;

    n25q_page_prog_seq #(.POLL_MAX(20'd3)) dut (
        .ifclk(ifclk), .reset(reset), .start(start), .page_addr(page_addr),
        .nbytes(nbytes), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done), .error(error), .status(status),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
        .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
        .di_write_mode(di_write_mode), .di_write(di_write), .di_len(di_len),
        .di_reg_datai(di_reg_datai), .di_read_rdy(di_read_rdy),
        .di_write_rdy(di_write_rdy), .di_reg_datao(di_reg_datao)
    );

    always #5 ifclk = ~ifclk;

    // payload source and RDSR response
    always_comb begin
        acc_rel      = acc_cnt - acc_base;
        wr_valid     = (acc_rel < feed_n);
        wr_data      = feed[acc_rel[1:0]];
        sts_byte     = (wip_stuck || ((rd_cnt - rd_base) < wip_polls)) ? 8'h83 : 8'h00;
        di_reg_datao = {16'h0000, sts_byte, 8'h5A};
    end

    // N25Q terminal model: data-terminal ready drops for three cycles after a strobe
    always @(posedge ifclk) begin
        if (reset) begin
            di_write_rdy <= 1'b1;
            di_read_rdy  <= 1'b1;
            dly          <= 3'd0;
            csb          <= 1'b1;
        end else begin
            if (dly != 3'd0) begin
                dly <= dly - 3'd1;
                if (dly == 3'd1) begin
                    di_write_rdy <= 1'b1;
                    di_read_rdy  <= 1'b1;
                end
            end
            if ((di_write || di_read_req) && log_n < 128) begin
                lg_term[log_n] <= di_term_addr;
                lg_data[log_n] <= di_reg_datai;
                lg_len[log_n]  <= di_len;
                lg_rd[log_n]   <= di_read_req;
                log_n          <= log_n + 1;
            end
            if (di_write && di_term_addr == C_CTRL && di_reg_addr == 32'd0)
                csb <= di_reg_datai[0];
            if (di_write && di_term_addr != C_CTRL) begin
                di_write_rdy <= 1'b0;
                dly          <= 3'd3;
            end
            if (di_read_req) begin
                di_read_rdy <= 1'b0;
                dly         <= 3'd3;
            end
        end
        if (di_read)             rd_cnt   <= rd_cnt + 1;
        if (wr_valid && wr_ready) acc_cnt <= acc_cnt + 1;
        if (done)                done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input int idx, input logic [15:0] term,
                           input logic [31:0] data, input logic [31:0] len, input logic rd);
        chk($sformatf("%s[%0d]", tag, idx),
            {lg_rd[idx], lg_term[idx], lg_data[idx], lg_len[idx][14:0]},
            {rd, term, data, len[14:0]});
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [8:0] n);
        @(negedge ifclk);
        page_addr = a;
        nbytes    = n;
        start     = 1'b1;
        @(negedge ifclk);
        start     = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int maxc);
        logic ended;
        ended = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge ifclk);
            if (done || error) begin
                ended = 1'b1;
                break;
            end
        end
        chk({tag, "_finished"}, 64'(ended), 64'd1);
    endtask

    task automatic new_test(input int polls, input logic stuck);
        rd_base   = rd_cnt;
        acc_base  = acc_cnt;
        wip_polls = polls;
        wip_stuck = stuck;
    endtask

    initial begin
        int b, d0;
        logic seen;

        repeat (3) @(negedge ifclk);
        reset = 1'b0;
        @(negedge ifclk);
        chk("rst_flags", {busy, done, error, wr_ready, di_read_mode, di_read_req,
                          di_read, di_write_mode, di_write}, 64'd0);
        chk("rst_term_len", {di_term_addr, di_len}, 64'd0);
        chk("rst_status", 64'(status), 64'd0);

        // basic 4-byte program, ready on first poll
        new_test(0, 1'b0);
        feed[0] = 32'hDDCCBBAA; feed_n = 1;
        b = log_n; d0 = done_cnt;
        pulse_start(24'h123456, 9'd4);
        wait_end("t1", 400);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_nxfer", 64'(log_n - b), 64'd10);
        chk_ent("t1", b + 0, C_CTRL, 32'd0, 32'd4, 1'b0);
        chk_ent("t1", b + 1, C_DATA, 32'h06, 32'd1, 1'b0);
        chk_ent("t1", b + 2, C_CTRL, 32'd1, 32'd4, 1'b0);
        chk_ent("t1", b + 3, C_CTRL, 32'd0, 32'd4, 1'b0);
        chk_ent("t1", b + 4, C_DATA, 32'h56341202, 32'd8, 1'b0);
        chk_ent("t1", b + 5, C_DATA, 32'hDDCCBBAA, 32'd8, 1'b0);
        chk_ent("t1", b + 6, C_CTRL, 32'd1, 32'd4, 1'b0);
        chk_ent("t1", b + 8, C_DATA, 32'h05, 32'd2, 1'b1);
        chk_ent("t1", b + 9, C_CTRL, 32'd1, 32'd4, 1'b0);
        chk("t1_status", 64'(status), 64'h00);
        chk("t1_reads", 64'(rd_cnt - rd_base), 64'd1);
        @(negedge ifclk);
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t1_idle", {busy, csb}, 64'b01);

        // 5-byte program with an extra word offered; WIP set for 3 polls
        new_test(3, 1'b0);
        feed[0] = 32'h11111111; feed[1] = 32'h22222222; feed[2] = 32'h33333333; feed_n = 3;
        b = log_n; d0 = done_cnt;
        pulse_start(24'h000100, 9'd5);
        wait_end("t2", 1000);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_nxfer", 64'(log_n - b), 64'd20);
        chk_ent("t2", b + 4, C_DATA, 32'h00010002, 32'd9, 1'b0);
        chk_ent("t2", b + 5, C_DATA, 32'h11111111, 32'd9, 1'b0);
        chk_ent("t2", b + 6, C_DATA, 32'h22222222, 32'd9, 1'b0);
        chk_ent("t2", b + 7, C_CTRL, 32'd1, 32'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk_ent("t2", b + 8 + 3 * k, C_CTRL, 32'd0, 32'd4, 1'b0);
            chk_ent("t2", b + 9 + 3 * k, C_DATA, 32'h05, 32'd2, 1'b1);
            chk_ent("t2", b + 10 + 3 * k, C_CTRL, 32'd1, 32'd4, 1'b0);
        end
        chk("t2_words", 64'(acc_cnt - acc_base), 64'd2);
        chk("t2_status", 64'(status), 64'h00);
        @(negedge ifclk);
        chk("t2_done_once", 64'(done_cnt - d0), 64'd1);

        // WIP stuck: initial poll plus 3 retries, then error with csb high
        new_test(0, 1'b1);
        feed[0] = 32'h0BADF00D; feed_n = 1;
        b = log_n; d0 = done_cnt;
        pulse_start(24'hABCDEF, 9'd4);
        wait_end("t3", 1000);
        chk("t3_err", {done, error}, 64'b01);
        chk("t3_nxfer", 64'(log_n - b), 64'd19);
        chk("t3_reads", 64'(rd_cnt - rd_base), 64'd4);
        chk_ent("t3", b + 4, C_DATA, 32'hEFCDAB02, 32'd8, 1'b0);
        chk_ent("t3", b + 18, C_CTRL, 32'd1, 32'd4, 1'b0);
        chk("t3_status", 64'(status), 64'h83);
        @(negedge ifclk);
        chk("t3_idle", {busy, csb}, 64'b01);
        chk("t3_no_done", 64'(done_cnt - d0), 64'd0);
        wip_stuck = 1'b0;

        // illegal lengths: error within two cycles, no bus traffic
        b = log_n;
        pulse_start(24'h000000, 9'd0);
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ifclk);
            if (error) seen = 1'b1;
        end
        chk("len0_err", 64'(seen), 64'd1);
        repeat (4) @(negedge ifclk);
        pulse_start(24'h000000, 9'd300);
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ifclk);
            if (error) seen = 1'b1;
        end
        chk("len300_err", 64'(seen), 64'd1);
        repeat (4) @(negedge ifclk);
        chk("badlen_nxfer", 64'(log_n - b), 64'd0);

        // reset while stalled in payload phase
        new_test(0, 1'b0);
        feed_n = 0;
        pulse_start(24'h000200, 9'd8);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge ifclk);
            if (wr_ready) seen = 1'b1;
        end
        chk("stall_reached", 64'(seen), 64'd1);
        repeat (5) @(negedge ifclk);
        chk("stall_held", {busy, wr_ready, csb}, 64'b110);
        reset = 1'b1;
        @(negedge ifclk);
        chk("midrst_flags", {busy, wr_ready, di_read_mode, di_read_req, di_read,
                             di_write_mode, di_write}, 64'd0);
        reset = 1'b0;
        @(negedge ifclk);

        // fresh run after reset with a start pulse while busy
        new_test(0, 1'b0);
        feed[0] = 32'hCAFEBABE; feed_n = 1;
        b = log_n; d0 = done_cnt;
        pulse_start(24'h000004, 9'd4);
        repeat (5) @(negedge ifclk);
        chk("busy_mid", 64'(busy), 64'd1);
        pulse_start(24'h777777, 9'd4);
        wait_end("t5", 400);
        repeat (40) @(negedge ifclk);
        chk("t5_nxfer", 64'(log_n - b), 64'd10);
        chk_ent("t5", b + 4, C_DATA, 32'h04000002, 32'd8, 1'b0);
        chk_ent("t5", b + 5, C_DATA, 32'hCAFEBABE, 32'd8, 1'b0);
        chk("t5_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t5_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n25q_page_prog_seq.md
Name: n25q_page_prog_seq

Overview:
- Upstream master for the N25Q data and control terminals.
- Takes a page-program request (24-bit flash address plus 1..256 bytes of payload streamed as 32-bit words).
- Drives the di_* bus through the full flash sequence:
  - WREN (0x06)
  - PAGE PROGRAM (0x02) with address and payload
  - RDSR (0x05) polling until WIP clears.
- Sits between the host command/FIFO logic and the N25Q controller, in the ifclk domain.

Parameters:
- TERM_CTRL, 16'h0010, terminal address of the N25Q control terminal.
- TERM_DATA, 16'h0011, terminal address of the N25Q data terminal.
- REG_CSB, 32'd0, control-terminal register holding csb (bit0; 1 = deselected).
- POLL_MAX, 20'd1000000, RDSR polls before error.

Ports:
- ifclk, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request; ignored unless idle.
- page_addr, input, 24, flash byte address.
- nbytes, input, 9, payload length 1..256; 0 or >256 → error.
- wr_data, input, 32, payload word; byte k of page in bits [8*(k%4)+7 : 8*(k%4)].
- wr_valid, input, 1, payload word valid.
- wr_ready, output, 1, payload word accepted when wr_valid && wr_ready.
- busy, output, 1, high from accepted start until done/error.
- done, output, 1, one-cycle pulse on success.
- error, output, 1, one-cycle pulse on bad length or poll timeout.
- status, output, 8, last RDSR value.
- di_term_addr, output, 16, to N25Q.
- di_reg_addr, output, 32, to N25Q.
- di_read_mode, output, 1, to N25Q.
- di_read_req, output, 1, to N25Q.
- di_read, output, 1, to N25Q.
- di_write_mode, output, 1, to N25Q.
- di_write, output, 1, to N25Q.
- di_len, output, 32, to N25Q.
- di_reg_datai, output, 32, to N25Q.
- di_read_rdy, input, 1, from N25Q.
- di_write_rdy, input, 1, from N25Q.
- di_reg_datao, input, 32, from N25Q.

Behaviour:
- Clock and reset: one clock (ifclk); reset is synchronous and active-high.
- Reset values:
  - All strobes, modes and di_len are 0.
  - di_term_addr = 0.
  - busy, done, error, wr_ready = 0; status = 0.
  - FSM returns to IDLE from any state. csb is not rewritten by this block; system reset of the control terminal restores csb=1.
- Byte lane order on di_reg_datai: first byte shifted is [7:0], then [15:8], [23:16], [31:24]. The same order applies to di_reg_datao on reads.
- Transfer primitive (sub-module):
  - Cycle 0: set term/reg/mode/len/data.
  - Cycle 1: one-cycle di_write (or di_read_req).
  - Cycle 2: wait, because the slave's rdy drops one cycle after the strobe.
  - Then wait for di_write_rdy/di_read_rdy = 1.
  - Mode and term stay held throughout a csb-low frame; di_len is the total frame byte count, constant for the frame.
- Control writes: term=TERM_CTRL, reg=REG_CSB, mode=write, len=4, data=0 or 1. Complete on the ready seen at cycle 2.
- Per-frame counters: between frames the terminal is switched to TERM_CTRL, which clears the slave byte counter.
- FSM sequence:
  1. IDLE: on start, latch page_addr and nbytes.
  2. Length check: if nbytes is 0 or >256 → ERR; else busy=1.
  3. WREN frame: CSLO → WREN (len 1, data 0x06) → CSHI.
  4. PP frame: CSLO → PP_HDR, len = 4+nbytes, data = {A[7:0],A[15:8],A[23:16],8'h02}.
  5. PP_DATA: wr_ready=1 for exactly one cycle per word, only when the primitive is idle. Each accepted word is issued as one write. ceil(nbytes/4) words total; the slave stops early on the last partial word.
  6. CSHI.
  7. POLL frame: CSLO → RDSR with read_mode=1, len 2, data 0x00000005, di_read_req.
  8. When rdy: pulse di_read and capture status = di_reg_datao[15:8]. → CSHI → CHECK.
  9. CHECK: if status[0]=1 and poll_cnt < POLL_MAX, return to the POLL frame; else if status[0]=1 → ERR; else → DONE.
  10. DONE / ERR: pulse done or error for one cycle, busy=0 → IDLE.
- Payload stall: wr_valid low stalls PP_DATA with csb held low; there is no timeout on payload.
- Extra words: wr_valid data beyond ceil(nbytes/4) is not consumed.
- start while busy: ignored, no queuing.
- ERR on poll timeout always leaves csb=1.

Decomposition:
- Shared package n25q_pkg holds:
  - Opcode constants OP_WREN=8'h06, OP_PP=8'h02, OP_RDSR=8'h05.
  - The FSM state enum.
  - The default terminal addresses.
- One sub-module, n25q_di_xfer: a single-transfer issue/wait engine (req/ack in; di_* out). The top FSM sequences calls to it.

Test Plan:
- start, addr 0x123456, nbytes 4, one word 0xDDCCBBAA; RDSR returns 0x00 first poll →
  - di writes in order: csb 0; 0x06 (len 1); csb 1; csb 0; 0x56341202 (len 8); 0xDDCCBBAA; csb 1.
  - Then one RDSR; done pulses; status = 0x00.
- nbytes 5 → two payload words; di_len = 9 on all writes in the PP frame; wr_ready accepts exactly 2 words.
- Flash model returns WIP=1 for 3 polls, then 0x00 → 4 RDSR frames, each bracketed by csb writes; done asserts once.
- POLL_MAX=2, WIP stuck 1 → 3 RDSR frames (initial plus 2 retries), error pulses, last di write is csb=1, busy drops.
- nbytes 0 and nbytes 300 → error pulse within 2 cycles, zero di_write strobes.
- Assert reset mid PP_DATA → next cycle all di strobes and modes 0, busy 0. A fresh start then completes normally. A start pulsed while busy produces no second sequence.
